// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: MIPS opcode/funct constants, encoder mnemonic codes and instruction field layouts
package mips_isa_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;

    localparam logic [4:0] M_ADD  = 5'd0;
    localparam logic [4:0] M_SUB  = 5'd1;
    localparam logic [4:0] M_AND  = 5'd2;
    localparam logic [4:0] M_OR   = 5'd3;
    localparam logic [4:0] M_NOR  = 5'd4;
    localparam logic [4:0] M_SLL  = 5'd5;
    localparam logic [4:0] M_SRL  = 5'd6;
    localparam logic [4:0] M_JR   = 5'd7;
    localparam logic [4:0] M_ADDI = 5'd8;
    localparam logic [4:0] M_ANDI = 5'd9;
    localparam logic [4:0] M_ORI  = 5'd10;
    localparam logic [4:0] M_LUI  = 5'd11;
    localparam logic [4:0] M_LW   = 5'd12;
    localparam logic [4:0] M_SW   = 5'd13;
    localparam logic [4:0] M_BEQ  = 5'd14;
    localparam logic [4:0] M_BNE  = 5'd15;
    localparam logic [4:0] M_J    = 5'd16;
    localparam logic [4:0] M_JAL  = 5'd17;

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } rFields_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [15:0] imm;
    } iFields_t;

    typedef struct packed {
        logic [5:0]  op;
        logic [25:0] target;
    } jFields_t;

    function automatic logic [5:0] mnemOp(input logic [4:0] m);
        case (m)
            M_ADDI:  return OP_ADDI;
            M_ANDI:  return OP_ANDI;
            M_ORI:   return OP_ORI;
            M_LUI:   return OP_LUI;
            M_LW:    return OP_LW;
            M_SW:    return OP_SW;
            M_BEQ:   return OP_BEQ;
            M_BNE:   return OP_BNE;
            M_J:     return OP_J;
            M_JAL:   return OP_JAL;
            default: return OP_RTYPE;
        endcase
    endfunction

    function automatic logic [5:0] mnemFunct(input logic [4:0] m);
        case (m)
            M_SUB:   return F_SUB;
            M_AND:   return F_AND;
            M_OR:    return F_OR;
            M_NOR:   return F_NOR;
            M_SLL:   return F_SLL;
            M_SRL:   return F_SRL;
            M_JR:    return F_JR;
            default: return F_ADD;
        endcase
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count-based full/empty; head reads 0 while empty
module sync_fifo #(
    parameter int W = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] wrData,
    input  logic         pop,
    output logic [W-1:0] rdData,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rdPtr, wrPtr;
    logic [AW:0]   count;
    logic          doPush, doPop;

    assign full   = count == (AW+1)'(DEPTH);
    assign empty  = count == '0;
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign rdData = empty ? '0 : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            rdPtr <= rdPtr + AW'(doPop);
            wrPtr <= wrPtr + AW'(doPush);
            count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
        end
    end

    always_ff @(posedge clk)
        if (doPush) mem[wrPtr] <= wrData;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs mnemonic+operand fields into MIPS words, queues them and tags each with its load address
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0040_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_illegal,
    output logic [15:0]       word_count
);
    logic     isShift, isJr, isR, isJ, legal, accept, push, pop, full, empty;
    rFields_t rWord;
    iFields_t iWord;
    jFields_t jWord;
    logic [31:0] word;

    assign isShift = mnem == M_SLL || mnem == M_SRL;
    assign isJr    = mnem == M_JR;
    assign isR     = mnem < M_ADDI;
    assign isJ     = mnem == M_J || mnem == M_JAL;
    assign legal   = mnem <= M_JAL;

    assign rWord = '{op: OP_RTYPE, rs: isShift ? 5'd0 : rs, rt: isJr ? 5'd0 : rt,
                     rd: isJr ? 5'd0 : rd, shamt: isShift ? shamt : 5'd0, funct: mnemFunct(mnem)};
    assign iWord = '{op: mnemOp(mnem), rs: mnem == M_LUI ? 5'd0 : rs, rt: rt, imm: imm};
    assign jWord = '{op: mnemOp(mnem), target: target};
    assign word  = isR ? rWord : isJ ? jWord : iWord;

    // Illegal mnemonics still complete the handshake but never reach the queue
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;
    assign in_ready  = !full;
    assign out_valid = !empty;

    sync_fifo #(.W(32), .DEPTH(DEPTH)) fifo (
        .clk(clk), .reset(reset), .clear(clear),
        .push(push), .wrData(word), .pop(pop),
        .rdData(out_word), .full(full), .empty(empty)
    );

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            out_addr    <= BASE_ADDR;
            word_count  <= '0;
            err_illegal <= 1'b0;
        end else begin
            if (pop) begin
                out_addr   <= out_addr + ADDR_W'(4);
                word_count <= word_count + 16'd1;
            end
            if (accept && !legal) err_illegal <= 1'b1;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed vectors with hand-assembled expected words and addresses
module tb_instr_encoder;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 0, reset = 0, clear = 0, in_valid = 0, out_ready = 0;
    logic [4:0]  mnem = 0, rs = 0, rt = 0, rd = 0, shamt = 0;
    logic [15:0] imm = 0;
    logic [25:0] target = 0;
    logic        in_ready, out_valid, err_illegal;
    logic [31:0] out_word, out_addr;
    logic [15:0] word_count;
    int          total = 0, bad = 0;

    instr_encoder dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
        .err_illegal(err_illegal), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic setFields(input logic [4:0] m, s, t, d, sh, input logic [15:0] im, input logic [25:0] tg);
        mnem = m; rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg;
    endtask

    task automatic pushOne(input logic [4:0] m, s, t, d, sh, input logic [15:0] im, input logic [25:0] tg);
        setFields(m, s, t, d, sh, im, tg);
        check("push.in_ready", in_ready, 1);
        in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    task automatic waitValid();
        int n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
    endtask

    task automatic popCheck(input string tag, input logic [31:0] w, input logic [31:0] a);
        waitValid();
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".word"}, out_word, w);
        check({tag, ".addr"}, out_addr, a);
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic checkIdle(input string tag);
        check({tag, ".out_valid"}, out_valid, 0);
        check({tag, ".in_ready"}, in_ready, 1);
        check({tag, ".out_word"}, out_word, 0);
        check({tag, ".out_addr"}, out_addr, BASE);
        check({tag, ".err"}, err_illegal, 0);
        check({tag, ".count"}, word_count, 0);
    endtask

    task automatic pulseClear();
        clear = 1; tick(); clear = 0;
    endtask

    initial begin
        logic took;
        tick(); tick();
        reset = 1;
        checkIdle("reset");

        // ADD $8,$9,$10 with no bypass: visible one edge after the push
        setFields(0, 9, 10, 8, 0, 0, 0);
        in_valid = 1;
        check("add.pre_valid", out_valid, 0);
        tick();
        in_valid = 0;
        check("add.valid_n1", out_valid, 1);
        popCheck("add", 32'h012A4020, BASE);
        check("add.count", word_count, 1);

        pulseClear();
        pushOne(8, 0, 8, 0, 0, 16'h0005, 0);
        pushOne(11, 7, 1, 0, 0, 16'h1001, 0);
        popCheck("addi", 32'h20080005, BASE);
        popCheck("lui", 32'h3C011001, BASE + 4);
        check("lui.count", word_count, 2);

        pushOne(5, 3, 9, 8, 2, 16'hFFFF, 0);
        pushOne(16, 1, 2, 3, 4, 16'h1234, 26'h0100000);
        pushOne(15, 8, 9, 0, 0, 16'hFFFE, 0);
        popCheck("sll", 32'h00094080, BASE + 8);
        popCheck("j", 32'h08100000, BASE + 12);
        popCheck("bne", 32'h1509FFFE, BASE + 16);
        pushOne(7, 31, 5, 5, 5, 0, 0);
        pushOne(0, 9, 10, 8, 7, 0, 0);
        popCheck("jr", 32'h03E00008, BASE + 20);
        popCheck("add_shamt0", 32'h012A4020, BASE + 24);

        // Backpressure: four fill the FIFO, the fifth must wait
        pulseClear();
        for (int i = 0; i < 4; i++) pushOne(8, 0, 5'(i), 0, 0, 16'(i), 0);
        check("full.in_ready", in_ready, 0);
        setFields(8, 0, 4, 0, 0, 16'd4, 0);
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold.in_ready", in_ready, 0);
            check("hold.word", out_word, 32'h20000000);
            check("hold.addr", out_addr, BASE);
        end
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            waitValid();
            check("drain.word", out_word, 32'h20000000 | (32'(i) << 16) | 32'(i));
            check("drain.addr", out_addr, BASE + 32'(4 * i));
            took = in_valid && in_ready;
            tick();
            if (took) in_valid = 0;
        end
        out_ready = 0;
        check("drain.in_valid_dropped", in_valid, 0);
        check("drain.empty", out_valid, 0);
        check("drain.count", word_count, 5);

        pulseClear();
        pushOne(0, 1, 2, 3, 0, 0, 0);
        pushOne(20, 1, 2, 3, 0, 0, 0);
        check("illegal.err", err_illegal, 1);
        pushOne(0, 4, 5, 6, 0, 0, 0);
        popCheck("illegal.add0", 32'h00221820, BASE);
        popCheck("illegal.add1", 32'h00853020, BASE + 4);
        check("illegal.empty", out_valid, 0);
        check("illegal.count", word_count, 2);
        check("illegal.sticky", err_illegal, 1);

        // Clear with three buffered and a handshake offered in the same cycle
        pulseClear();
        for (int i = 0; i < 3; i++) pushOne(0, 1, 2, 3, 0, 0, 0);
        pushOne(25, 0, 0, 0, 0, 0, 0);
        popCheck("preclear", 32'h00221820, BASE);
        setFields(0, 9, 10, 8, 0, 0, 0);
        in_valid = 1; clear = 1;
        tick();
        in_valid = 0; clear = 0;
        checkIdle("clear");
        pushOne(8, 0, 8, 0, 0, 16'h0005, 0);
        popCheck("postclear", 32'h20080005, BASE);

        for (int i = 0; i < 3; i++) pushOne(0, 1, 2, 3, 0, 0, 0);
        pushOne(31, 0, 0, 0, 0, 0, 0);
        reset = 0; clear = 1;
        tick();
        reset = 1; clear = 0;
        checkIdle("midreset");
        pushOne(11, 7, 1, 0, 0, 16'h1001, 0);
        popCheck("postreset", 32'h3C011001, BASE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Reverse of the opcode decoder. Takes decoded instruction fields (a mnemonic code plus operands) and packs them into 32-bit MIPS machine words.
- Buffers the words in a small FIFO and presents each one with its target program-memory address to the instruction-memory loader.
- Used by the boot/program loader and by the test harness to build programs without pre-assembled hex files.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- ADDR_W, 32, width of the output address.
- BASE_ADDR, 32'h0040_0000, address of the first emitted word; +4 per word.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- clear  in  1  synchronous flush: empties the FIFO, reloads the address, clears err_illegal.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept; equals not-full.
- mnem  in  5  mnemonic code (see Behaviour).
- rs  in  5  source register.
- rt  in  5  target register.
- rd  in  5  destination register.
- shamt  in  5  shift amount.
- imm  in  16  immediate or branch offset.
- target  in  26  jump target field.
- out_valid  out  1  head word valid.
- out_ready  in  1  loader accepts the head word.
- out_word  out  32  encoded instruction.
- out_addr  out  ADDR_W  memory address of out_word.
- err_illegal  out  1  sticky; set when an illegal mnemonic is accepted.
- word_count  out  16  number of words emitted since reset/clear; wraps.

Behaviour:
- Mnemonic map, R-type (opcode 0, funct in hex):
  - 0 ADD (20), 1 SUB (22), 2 AND (24), 3 OR (25), 4 NOR (27)
  - 5 SLL (00), 6 SRL (02), 7 JR (08)
- Mnemonic map, I-type (opcode in hex):
  - 8 ADDI (08), 9 ANDI (0C), 10 ORI (0D), 11 LUI (0F)
  - 12 LW (23), 13 SW (2B), 14 BEQ (04), 15 BNE (05)
- Mnemonic map, J-type (opcode in hex): 16 J (02), 17 JAL (03).
- Codes 18-31 are illegal.
- Packing:
  - R-type: {6'h00, rs, rt, rd, shamt, funct}.
  - SLL/SRL force rs=0.
  - JR forces rt=rd=shamt=0.
  - Other R-type force shamt=0.
  - I-type: {op, rs, rt, imm}; LUI forces rs=0.
  - J-type: {op, target}.
  - Unused input fields are ignored.
- Push:
  - Occurs on in_valid && in_ready at a rising edge.
  - Encoding is combinational; the word is written into the FIFO tail.
  - Latency: a word pushed at edge N is visible at the head at edge N+1 if the FIFO was empty. There is no combinational bypass.
- Illegal mnemonic:
  - The input is still consumed (handshake completes) and nothing is written.
  - err_illegal is set at the same edge and holds until reset or clear.
- Pop:
  - Occurs on out_valid && out_ready. The head advances.
  - out_addr increments by 4 and wraps modulo 2^ADDR_W.
  - word_count increments by 1 and wraps at 16'hFFFF -> 0.
- out_valid = FIFO not empty. out_word and out_addr hold stable while out_valid && !out_ready.
- in_ready = FIFO not full, independent of out_ready. Pushing into a full FIFO is not allowed even if a pop happens in the same cycle.
- Simultaneous push and pop when not empty and not full: occupancy unchanged, both complete.
- Pointers: log2(DEPTH)-bit read/write indices plus a (log2(DEPTH)+1)-bit count. Full is count==DEPTH; empty is count==0.
- Reset values (reset low at an edge), also applied by clear:
  - FIFO empty, out_valid=0, in_ready=1
  - out_addr=BASE_ADDR, err_illegal=0, word_count=0
  - out_word reads 0 while empty
- Priority: reset over clear over push/pop. A handshake in the same cycle as clear is discarded.
- Reset or clear mid-stream drops all buffered words. There is no partial-state carry-over.

Decomposition:
- Package mips_isa_pkg holds:
  - opcode localparams (shared with the control decoder)
  - funct localparams
  - the 5-bit mnemonic code constants
  - a packed struct for the R/I/J field layouts
- Sub-module sync_fifo (parameterised width 32, DEPTH) holds the buffering.
- The encoder top holds the combinational packer, the address counter, word_count and the error flag.

Test Plan:
- Reset, then push ADD rs=9 rt=10 rd=8 -> next cycle out_valid=1, out_word=0x012A4020, out_addr=0x00400000.
- Push ADDI rs=0 rt=8 imm=5, then LUI rs=7 rt=1 imm=0x1001 with out_ready=1 -> words 0x20080005 @0x00400000, then 0x3C011001 @0x00400004 (rs forced 0); word_count=2.
- Push SLL rt=9 rd=8 shamt=2, J target=0x0100000, BNE rs=8 rt=9 imm=0xFFFE -> 0x00094080, 0x08100000, 0x1509FFFE, in order.
- Hold out_ready=0 and push 5 valid words -> in_ready drops after the 4th; the 5th waits; head word and address stay stable. Then out_ready=1 drains all 5 with contiguous addresses.
- Push mnem=20 between two ADDs -> in_ready stays 1, err_illegal=1, only the 2 ADD words emitted at consecutive addresses.
- With 3 words buffered, pulse clear (and separately reset low) -> out_valid=0 next cycle, err_illegal=0, next word emitted at 0x00400000.
